demux_scheduler: RTL and testbench
==================================

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 SHALL provide parameter DWELL, default 4, meaning the maximum cycles one requester holds the demux per grant (legal range 1..16).
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port req  input  8  request vector; bit i set means requester i wants demux output i.
REQ-005 SHALL provide port sel  output  3  demux select; sel[0]=a, sel[1]=b, sel[2]=c.
REQ-006 SHALL provide port en  output  1  demux enable (drives e).
REQ-007 SHALL provide port grant  output  8  one-hot grant; equals (en ? 1<<sel : 0).
REQ-008 SHALL provide port busy  output  1  high while in state GRANT.

Function
REQ-009 SHALL implement two states, IDLE and GRANT, a 3-bit round-robin pointer ptr, and a dwell counter cnt of width ceil(log2(DWELL))+1.
REQ-010 SHALL register sel, en, grant and busy; no combinational path from req to any output.
REQ-011 In IDLE: en=0, grant=0, busy=0, and sel holds its last value.
REQ-012 In IDLE with req!=0: winner = first set bit of req searching ptr+1, ptr+2, ... modulo 8.
REQ-013 On that edge: go to GRANT, sel=winner, en=1, grant=1<<winner, busy=1, cnt=DWELL-1.
REQ-014 Latency: req sampled high in IDLE -> en=1 on the next cycle.
REQ-015 In IDLE with req==0: remain in IDLE with no state change.
REQ-016 In GRANT, each edge, checks in priority order:
  - req[sel]==0 -> IDLE;
  - else cnt==0 -> IDLE;
  - else cnt=cnt-1 and remain in GRANT.
REQ-017 Every GRANT->IDLE transition SHALL load ptr=sel, so the just-served requester has lowest priority next.
REQ-018 Grant length SHALL be exactly DWELL cycles when req[sel] stays high, and N+1 cycles when req[sel] first samples low on the edge ending grant cycle N+1 (N = cycles before the drop).
REQ-019 Back-to-back grants SHALL be separated by exactly one IDLE cycle with en=0 (guaranteed dead time for demux select change).
REQ-020 sel SHALL never change while en=1.
REQ-021 Changes to req bits other than req[sel] during GRANT SHALL not affect the current grant.
REQ-022 A single persistent requester SHALL be re-granted after the one-cycle gap (ptr wrap reaches itself).
REQ-023 DWELL=1: every grant SHALL last one cycle, then one IDLE cycle.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for a clock edge, force: state=IDLE, ptr=7, cnt=0, sel=0, en=0, grant=0, busy=0.
REQ-025 With ptr=7 after reset, requester 0 SHALL have highest priority for the first arbitration.
REQ-026 Reset asserted mid-GRANT SHALL abort the grant; after release, arbitration restarts from ptr=7.
REQ-027 First arbitration after rst deasserts SHALL occur on the first rising edge with rst=0.

Verification
REQ-028 Reset: rst=1 mid-cycle with en=1 -> en=0, grant=8'h00, sel=3'd0 before the next clk edge.
REQ-029 Single requester: DWELL=4, req=8'h01 held -> pattern repeats: 4 cycles of grant=8'h01, en=1, sel=0, then 1 cycle of en=0.
REQ-030 Fair rotation: req=8'hFF held -> grants in order 0,1,2,...,7,0, each 4 cycles, separated by 1 idle cycle.
REQ-031 Early release: req=8'h08 -> grant=8'h08 starts; req drops to 0 after 2 grant cycles -> grant lasts 3 cycles total, en=0 after, ptr=3.
REQ-032 Priority after service: req=8'h22 -> requester 1 granted first, then requester 5, then requester 1.
REQ-033 Edge DWELL=1: req=8'h81 -> alternate grant=8'h01 and grant=8'h80, one cycle each, with one-cycle gaps; assert grant==(en?1<<sel:0) every cycle.

Source files
------------

// File: rtl/demux_scheduler.sv
// demux_scheduler
// Round-robin scheduler for an 8-way demux. Each requester is granted the
// demux for at most DWELL cycles. Consecutive grants are always separated by
// one idle cycle with en low, which gives the select lines dead time to change.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : request vector; bit i asks for demux output i
//   sel   : registered demux select (sel[0]=a, sel[1]=b, sel[2]=c)
//   en    : registered demux enable (drives e)
//   grant : registered one-hot grant, equal to (en ? 1<<sel : 0)
//   busy  : high while a grant is in progress
module demux_scheduler #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] grant,
  output logic       busy
);

  localparam int CW = $clog2(DWELL) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    sel_nxt;
  logic          en_nxt;
  logic [7:0]    grant_nxt;
  logic          busy_nxt;

  // Round-robin search: first set bit of req starting just after ptr.
  // The eighth step wraps back to ptr itself, so a lone persistent
  // requester can win again.
  logic          found;
  logic [2:0]    winner;
  logic [2:0]    idx;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    en_nxt    = en;
    grant_nxt = grant;
    busy_nxt  = busy;

    case (state)
      IDLE: begin
        en_nxt    = 1'b0;
        grant_nxt = 8'h00;
        busy_nxt  = 1'b0;
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          en_nxt    = 1'b1;
          grant_nxt = 8'h01 << winner;
          busy_nxt  = 1'b1;
          cnt_nxt   = CW'(DWELL - 1);
        end
      end

      GRANT: begin
        // Drop of the served request has priority over dwell expiry; both
        // end the grant the same way. Other req bits are ignored here.
        if (!req[sel] || cnt == '0) begin
          state_nxt = IDLE;
          ptr_nxt   = sel;  // just-served requester becomes lowest priority
          en_nxt    = 1'b0;
          grant_nxt = 8'h00;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        en_nxt    = 1'b0;
        grant_nxt = 8'h00;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd7;  // requester 0 wins the first arbitration
      cnt   <= '0;
      sel   <= 3'd0;
      en    <= 1'b0;
      grant <= 8'h00;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      en    <= en_nxt;
      grant <= grant_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
// Testbench for demux_scheduler: directed vectors with hand-computed
// expected values. One instance uses DWELL=4, a second uses DWELL=1.
module tb_demux_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic [7:0] grant;
  logic       busy;

  logic [7:0] req1;
  logic [2:0] sel1;
  logic       en1;
  logic [7:0] grant1;
  logic       busy1;

  int n_checks;
  int n_fail;

  demux_scheduler #(.DWELL(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .sel(sel), .en(en), .grant(grant), .busy(busy)
  );

  demux_scheduler #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .sel(sel1), .en(en1), .grant(grant1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and release it just after an edge, so the
  // following edge is the first arbitration.
  task automatic do_reset();
    rst  = 1'b1;
    req  = 8'h00;
    req1 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Asynchronous reset at time zero, before any clock edge.
    rst  = 1'b1;
    req  = 8'h00;
    req1 = 8'h00;
    #2;
    if (en !== 1'b0 || grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: en=%b grant=%h sel=%0d busy=%b, expected 0 00 0 0",
               en, grant, sel, busy);
    end
    n_checks++;
    do_reset();

    // Start a grant to requester 2, then assert reset mid-cycle.
    req = 8'h04;
    tick();
    if (en !== 1'b1 || grant !== 8'h04 || sel !== 3'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_grant: en=%b grant=%h sel=%0d busy=%b, expected 1 04 2 1",
               en, grant, sel, busy);
    end
    n_checks++;
    tick();
    #2;
    rst = 1'b1;
    #1;
    if (en !== 1'b0 || grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: en=%b grant=%h sel=%0d busy=%b, expected 0 00 0 0",
               en, grant, sel, busy);
    end
    n_checks++;

    // Release with requests 2 and 7 pending: ptr restarts at 7, so 2 wins,
    // and en rises right after the first edge with rst low.
    tick();
    rst = 1'b0;
    req = 8'h84;
    if (en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: en=%b, expected 0", en);
    end
    n_checks++;
    tick();
    if (en !== 1'b1 || grant !== 8'h04 || sel !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_restart: en=%b grant=%h sel=%0d, expected 1 04 2",
               en, grant, sel);
    end
    n_checks++;
  endtask

  // req=01 held: four grant cycles then one idle cycle, repeating.
  task automatic test_single();
    logic       exp_en;
    logic [7:0] exp_g;
    do_reset();
    req = 8'h01;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_en = (k % 5) != 4;
      exp_g  = exp_en ? 8'h01 : 8'h00;
      if (en !== exp_en || grant !== exp_g || sel !== 3'd0 || busy !== exp_en) begin
        n_fail++;
        $display("FAIL single k=%0d: en=%b grant=%h sel=%0d busy=%b, expected %b %h 0 %b",
                 k, en, grant, sel, busy, exp_en, exp_g, exp_en);
      end
      n_checks++;
    end
  endtask

  // req=FF held: grants 0..7 then 0 again, each four cycles plus one idle.
  task automatic test_rotation();
    logic       exp_en;
    logic [2:0] exp_s;
    logic [7:0] exp_g;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 45; k++) begin
      tick();
      exp_en = (k % 5) != 4;
      exp_s  = 3'((k / 5) % 8);
      exp_g  = exp_en ? (8'h01 << exp_s) : 8'h00;
      if (en !== exp_en || grant !== exp_g || sel !== exp_s || busy !== exp_en) begin
        n_fail++;
        $display("FAIL rotation k=%0d: en=%b grant=%h sel=%0d busy=%b, expected %b %h %0d %b",
                 k, en, grant, sel, busy, exp_en, exp_g, exp_s, exp_en);
      end
      n_checks++;
    end
  endtask

  // req=08, dropped after two grant cycles: grant lasts three cycles and
  // ptr becomes 3, so a following req=18 is won by requester 4.
  task automatic test_early_release();
    do_reset();
    req = 8'h08;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) req = 8'h00;
      if (en !== 1'b1 || grant !== 8'h08 || sel !== 3'd3) begin
        n_fail++;
        $display("FAIL early_grant k=%0d: en=%b grant=%h sel=%0d, expected 1 08 3",
                 k, en, grant, sel);
      end
      n_checks++;
    end
    tick();
    if (en !== 1'b0 || grant !== 8'h00 || busy !== 1'b0 || sel !== 3'd3) begin
      n_fail++;
      $display("FAIL early_end: en=%b grant=%h busy=%b sel=%0d, expected 0 00 0 3",
               en, grant, busy, sel);
    end
    n_checks++;
    req = 8'h18;
    tick();
    if (en !== 1'b1 || grant !== 8'h10 || sel !== 3'd4) begin
      n_fail++;
      $display("FAIL early_ptr: en=%b grant=%h sel=%0d, expected 1 10 4",
               en, grant, sel);
    end
    n_checks++;
  endtask

  // req=22: requester 1, then 5, then 1 again.
  task automatic test_priority();
    logic       exp_en;
    logic [2:0] exp_s;
    logic [7:0] exp_g;
    do_reset();
    req = 8'h22;
    for (int k = 0; k < 11; k++) begin
      tick();
      exp_en = (k % 5) != 4;
      exp_s  = ((k / 5) % 2 == 0) ? 3'd1 : 3'd5;
      exp_g  = exp_en ? (8'h01 << exp_s) : 8'h00;
      if (en !== exp_en || grant !== exp_g || sel !== exp_s) begin
        n_fail++;
        $display("FAIL priority k=%0d: en=%b grant=%h sel=%0d, expected %b %h %0d",
                 k, en, grant, sel, exp_en, exp_g, exp_s);
      end
      n_checks++;
    end
  endtask

  // Other req bits toggling during a grant leave it untouched; afterwards
  // requester 3 follows requester 2.
  task automatic test_other_bits();
    logic       exp_en;
    logic [2:0] exp_s;
    logic [7:0] exp_g;
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) req = 8'h0C;
      if (k == 1) req = 8'h6C;
      if (k == 2) req = 8'h0C;
      exp_en = k != 4;
      exp_s  = (k < 5) ? 3'd2 : 3'd3;
      exp_g  = exp_en ? (8'h01 << exp_s) : 8'h00;
      if (en !== exp_en || grant !== exp_g || sel !== exp_s) begin
        n_fail++;
        $display("FAIL other_bits k=%0d: en=%b grant=%h sel=%0d, expected %b %h %0d",
                 k, en, grant, sel, exp_en, exp_g, exp_s);
      end
      n_checks++;
    end
  endtask

  // DWELL=1, req=81: one-cycle grants alternating 0 and 7 with one-cycle gaps.
  task automatic test_dwell1();
    logic       exp_en;
    logic [2:0] exp_s;
    logic [7:0] exp_g;
    do_reset();
    req1 = 8'h81;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_en = (k % 2) == 0;
      exp_s  = ((k / 2) % 2 == 0) ? 3'd0 : 3'd7;
      exp_g  = exp_en ? (8'h01 << exp_s) : 8'h00;
      if (en1 !== exp_en || grant1 !== exp_g || sel1 !== exp_s || busy1 !== exp_en) begin
        n_fail++;
        $display("FAIL dwell1 k=%0d: en=%b grant=%h sel=%0d busy=%b, expected %b %h %0d %b",
                 k, en1, grant1, sel1, busy1, exp_en, exp_g, exp_s, exp_en);
      end
      n_checks++;
      if (grant1 !== (en1 ? (8'h01 << sel1) : 8'h00)) begin
        n_fail++;
        $display("FAIL dwell1_onehot k=%0d: grant=%h en=%b sel=%0d",
                 k, grant1, en1, sel1);
      end
      n_checks++;
    end
    // The DWELL=4 instance saw no requests and must still be idle.
    if (en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dwell1_other_idle: en=%b busy=%b, expected 0 0", en, busy);
    end
    n_checks++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_priority();
    test_other_bits();
    test_dwell1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
